// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU clock-enable controller: operating modes and FSM states.
package cpu_clk_pkg;

  localparam logic [1:0] MODE_STOP = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_SLOW = 2'b10;
  localparam logic [1:0] MODE_FAST = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  // Slow and fast are the two free-running modes; both share the upper mode bit.
  function automatic logic is_run_mode(input logic [1:0] m);
    return m[1];
  endfunction

endpackage

// File: rtl/edge_rise_det.sv
// One-bit rising-edge detector: remembers the previous sample and flags a 0->1 change.
module edge_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic prev;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) prev <= 1'b0;
    else        prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/cpu_clock_controller.sv
// Generates the CPU pipeline clock-enable (stop / step / slow / fast), honouring halt and resume.
// Optional breakpoint comparator is built when CPU_CLOCK_BREAKPOINT_EN is defined.
module cpu_clock_controller
  import cpu_clk_pkg::*;
#(
  parameter int DIV_SLOW = 25000000,
  parameter int CNT_W    = 32
`ifdef CPU_CLOCK_BREAKPOINT_EN
  , parameter int PC_W   = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             step_btn,
  input  logic             resume,
  input  logic             halt,
  output logic             cpu_en,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] tick_count,
  output logic [1:0]       state_dbg
`ifdef CPU_CLOCK_BREAKPOINT_EN
  , input  logic [PC_W-1:0] pc
  , input  logic [PC_W-1:0] bp_addr
  , input  logic            bp_valid
  , output logic            bp_hit
`endif
);

  localparam int DIV_W = (DIV_SLOW > 2) ? $clog2(DIV_SLOW) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_SLOW - 1);

  state_t           state;
  logic [1:0]       mode_q;
  logic [DIV_W-1:0] div_cnt;
  logic             step_rise;
  logic             resume_rise;
  logic             bp_fire;
  logic             pulse;

  edge_rise_det u_step_det (
    .clk  (clk),
    .reset(reset),
    .din  (step_btn),
    .rise (step_rise)
  );

  edge_rise_det u_resume_det (
    .clk  (clk),
    .reset(reset),
    .din  (resume),
    .rise (resume_rise)
  );

`ifdef CPU_CLOCK_BREAKPOINT_EN
  logic            bp_skip;
  logic [PC_W-1:0] bp_skip_pc;

  // After a resume the halting pc is masked until the core moves off it.
  assign bp_fire = (state == ST_RUN) && bp_valid && (pc == bp_addr)
                   && !(bp_skip && (pc == bp_skip_pc));

  always_ff @(posedge clk) begin
    if (!reset) begin
      bp_hit     <= 1'b0;
      bp_skip    <= 1'b0;
      bp_skip_pc <= '0;
    end else if (bp_fire && !halt) begin
      bp_hit <= 1'b1;
    end else if ((state == ST_HALT) && resume_rise && !halt) begin
      bp_hit <= 1'b0;
      if (bp_hit) begin
        bp_skip    <= 1'b1;
        bp_skip_pc <= pc;
      end
    end else if (bp_skip && (pc != bp_skip_pc)) begin
      bp_skip <= 1'b0;
    end
  end
`else
  assign bp_fire = 1'b0;
`endif

  // A pulse needs a stable mode: a mode change in RUN swallows any pending wrap.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    pulse = 1'b0;
    if (!halt) begin
      case (state)
        ST_IDLE: pulse = (mode == MODE_STEP) && step_rise;
        ST_RUN:  pulse = !bp_fire && (mode == mode_q)
                         && ((mode == MODE_FAST)
                             || ((mode == MODE_SLOW) && (div_cnt == DIV_LAST)));
        default: pulse = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_STOP;
      div_cnt    <= '0;
      cpu_en     <= 1'b0;
      tick_count <= '0;
      running    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      mode_q  <= mode;
      cpu_en  <= pulse;
      div_cnt <= '0;
      if (pulse) tick_count <= tick_count + CNT_W'(1);

      case (state)
        ST_IDLE: begin
          if (halt) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (is_run_mode(mode)) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (halt || bp_fire) begin
            state   <= ST_HALT;
            running <= 1'b0;
            halted  <= 1'b1;
          end else if (!is_run_mode(mode)) begin
            state   <= ST_IDLE;
            running <= 1'b0;
          end else if ((mode == MODE_SLOW) && (mode == mode_q) && (div_cnt != DIV_LAST)) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        ST_HALT: begin
          if (resume_rise && !halt) begin
            state  <= ST_IDLE;
            halted <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Self-checking bench for cpu_clock_controller: directed scenarios plus random stimulus vs a behavioural model.
module tb_cpu_clock_controller;

  localparam int DIV = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          step_btn = 1'b0;
  logic          resume = 1'b0;
  logic          halt = 1'b0;
  logic          cpu_en;
  logic          running;
  logic          halted;
  logic [CW-1:0] tick_count;
  logic [1:0]    state_dbg;
`ifdef CPU_CLOCK_BREAKPOINT_EN
  logic [31:0]   pc = '0;
  logic [31:0]   bp_addr = '0;
  logic          bp_valid = 1'b0;
  logic          bp_hit;
`endif

  always #5 clk = ~clk;

  cpu_clock_controller #(
    .DIV_SLOW(DIV),
    .CNT_W   (CW)
`ifdef CPU_CLOCK_BREAKPOINT_EN
    , .PC_W  (32)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .step_btn  (step_btn),
    .resume    (resume),
    .halt      (halt),
    .cpu_en    (cpu_en),
    .running   (running),
    .halted    (halted),
    .tick_count(tick_count),
    .state_dbg (state_dbg)
`ifdef CPU_CLOCK_BREAKPOINT_EN
    , .pc      (pc)
    , .bp_addr (bp_addr)
    , .bp_valid(bp_valid)
    , .bp_hit  (bp_hit)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  bit use_model = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: states 0 idle / 1 run / 2 halt, run_age counts RUN cycles at a stable mode.
  int         m_state = 0;
  bit         m_en = 1'b0;
  int         m_tick = 0;
  int         m_age = 0;
  logic [1:0] m_mode_prev = 2'b00;
  bit         m_step_prev = 1'b0;
  bit         m_res_prev = 1'b0;

  task automatic model_step();
    bit step_edge;
    bit res_edge;
    if (!reset) begin
      m_state = 0; m_en = 0; m_tick = 0; m_age = 0;
      m_mode_prev = 2'b00; m_step_prev = 0; m_res_prev = 0;
      return;
    end
    step_edge = step_btn && !m_step_prev;
    res_edge  = resume && !m_res_prev;
    m_en = 0;
    if (m_state == 2) begin
      if (res_edge && !halt) m_state = 0;
    end else if (halt) begin
      m_state = 2;
    end else if (m_state == 0) begin
      if (mode >= 2) begin
        m_state = 1;
        m_age = 0;
      end else if (mode == 1 && step_edge) begin
        m_en = 1;
      end
    end else begin
      if (mode < 2) m_state = 0;
      else if (mode != m_mode_prev) m_age = 0;
      else begin
        m_age++;
        m_en = (mode == 3) || (m_age % DIV == 0);
      end
    end
    if (m_en) m_tick = (m_tick + 1) % (1 << CW);
    m_step_prev = step_btn;
    m_res_prev  = resume;
    m_mode_prev = mode;
  endtask

  task automatic cyc(input logic r, input logic [1:0] md, input logic sb, input logic rs, input logic h);
    @(negedge clk);
    reset = r; mode = md; step_btn = sb; resume = rs; halt = h;
    if (use_model) model_step();
    @(posedge clk);
    #1;
    if (cpu_en) pulses++;
    if (use_model) begin
      check("cpu_en",     cpu_en,     m_en);
      check("tick_count", tick_count, m_tick);
      check("state_dbg",  state_dbg,  m_state);
      check("running",    running,    m_state == 1);
      check("halted",     halted,     m_state == 2);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] rm;
    logic rsb, rrb, rh;

    repeat (2) cyc(0, 2'd0, 0, 0, 0);
    check("reset_tick",  tick_count, 0);
    check("reset_state", state_dbg,  0);

    // Slow run: pulses 4, 8, 12 cycles after RUN entry.
    pulses = 0;
    repeat (13) cyc(1, 2'd2, 0, 0, 0);
    check("slow_pulses", pulses,     3);
    check("slow_tick",   tick_count, 3);

    // Fast run for 10 cycles, then halt.
    cyc(0, 2'd0, 0, 0, 0);
    pulses = 0;
    repeat (11) cyc(1, 2'd3, 0, 0, 0);
    check("fast_pulses", pulses,     10);
    check("fast_tick",   tick_count, 10);
    cyc(1, 2'd3, 0, 0, 1);
    check("halt_en",     cpu_en,    0);
    check("halt_flag",   halted,    1);
    check("halt_dbg",    state_dbg, 2);

    // Resume is ignored while halt is still asserted.
    cyc(1, 2'd3, 0, 1, 1);
    cyc(1, 2'd3, 0, 0, 1);
    check("resume_ignored", state_dbg, 2);
    cyc(1, 2'd2, 0, 0, 0);
    cyc(1, 2'd2, 0, 1, 0);
    check("resume_idle", state_dbg, 0);
    cyc(1, 2'd2, 0, 0, 0);
    check("resume_run",  state_dbg, 1);

    // Step mode: a held button gives one pulse.
    cyc(0, 2'd0, 0, 0, 0);
    pulses = 0;
    repeat (20) cyc(1, 2'd1, 1, 0, 0);
    check("step_held",  pulses,     1);
    check("step_tick1", tick_count, 1);
    repeat (3) cyc(1, 2'd1, 0, 0, 0);
    cyc(1, 2'd1, 1, 0, 0);
    cyc(1, 2'd1, 0, 0, 0);
    check("step_tick2", tick_count, 2);

    // Counter wrap: 17 fast pulses on a 4-bit counter.
    cyc(0, 2'd0, 0, 0, 0);
    repeat (18) cyc(1, 2'd3, 0, 0, 0);
    check("wrap_tick", tick_count, 1);

    // Halt beats a simultaneous step edge.
    cyc(0, 2'd0, 0, 0, 0);
    cyc(1, 2'd1, 0, 0, 0);
    cyc(1, 2'd1, 1, 0, 1);
    check("halt_beats_step", cpu_en, 0);

    // Mode change on the divider wrap cycle suppresses the pulse.
    cyc(0, 2'd0, 0, 0, 0);
    cyc(1, 2'd2, 0, 0, 0);
    repeat (3) cyc(1, 2'd2, 0, 0, 0);
    cyc(1, 2'd3, 0, 0, 0);
    check("mode_chg_wrap", cpu_en, 0);

    // Reset in the middle of a pulse train.
    repeat (3) cyc(1, 2'd3, 0, 0, 0);
    cyc(0, 2'd3, 0, 0, 0);
    check("reset_mid_en",   cpu_en,     0);
    check("reset_mid_tick", tick_count, 0);

    // Randomised traffic against the model.
    rm = 2'd2; rsb = 0; rrb = 0; rh = 0;
    repeat (600) begin
      if ($urandom_range(15) == 0) rm = 2'($urandom_range(3));
      if (rh) rh = ($urandom_range(5) != 0);
      else    rh = ($urandom_range(39) == 0);
      if ($urandom_range(3) == 0) rsb = ~rsb;
      if ($urandom_range(5) == 0) rrb = ~rrb;
      cyc($urandom_range(99) != 0, rm, rsb, rrb, rh);
    end

`ifdef CPU_CLOCK_BREAKPOINT_EN
    use_model = 1'b0;
    bp_addr = 32'h40; bp_valid = 1'b1; pc = '0;
    cyc(0, 2'd0, 0, 0, 0);
    cyc(1, 2'd3, 0, 0, 0);
    for (int k = 1; k < 40 && !halted; k++) begin
      pc = 32'(4 * k);
      cyc(1, 2'd3, 0, 0, 0);
    end
    check("bp_halt_pc", pc,     32'h40);
    check("bp_halted",  halted, 1);
    check("bp_hit_set", bp_hit, 1);
    cyc(1, 2'd3, 0, 1, 0);
    check("bp_hit_clr",  bp_hit,    0);
    check("bp_resume",   state_dbg, 0);
    repeat (3) cyc(1, 2'd3, 0, 0, 0);
    check("bp_no_rehalt", running, 1);
    check("bp_hit_low",   bp_hit,  0);
    pc = 32'h44;
    cyc(1, 2'd3, 0, 0, 0);
    check("bp_moved_on", running, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_clock_controller.md
Name: cpu_clock_controller

Overview:
- Sequences the MIPS core's execution rate by producing a single-cycle clock-enable (cpu_en) on the system clock.
- Replaces the free-running slow-clock divider as the source of CPU stepping.
- Supports four modes: stop, single-step from a button, slow run at a divided rate, and fast run every cycle.
- Honours the CPU's halt output and provides a resume control plus a retired-tick counter for the board display.

Parameters:
DIV_SLOW, 25000000, clk cycles per cpu_en pulse in slow mode (≥2)
CNT_W, 32, width of tick_count
PC_W, 32, width of pc/bp_addr (used only with the optional feature)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low; all state cleared when 0 at a clk edge
mode  in  2  00 stop, 01 step, 10 slow, 11 fast
step_btn  in  1  already synchronized/debounced step button, level
resume  in  1  already synchronized resume button, level
halt  in  1  CPU halt-instruction flag, level
cpu_en  out  1  registered one-cycle enable to the CPU pipeline
running  out  1  high in RUN state
halted  out  1  high in HALT state
tick_count  out  CNT_W  number of cpu_en pulses issued; wraps modulo 2^CNT_W
state_dbg  out  2  encoded FSM state for LEDs

Behaviour:
- Reset (reset=0 at edge): state=IDLE; div_cnt=0; cpu_en=0; tick_count=0; step and resume edge-detect registers=0; running=0; halted=0.
- FSM states (state_dbg encoding): IDLE=00, RUN=01, HALT=10.
- IDLE→RUN when mode is 10 or 11 and halt=0.
- IDLE handles step: stays in IDLE when mode=01; each step_btn rising edge (step_btn=1, previous sample=0) sets cpu_en=1 on the next cycle only.
- RUN→IDLE when mode becomes 00 or 01.
- Any state except HALT → HALT when halt=1 is sampled. halt has priority over mode and step.
- HALT→IDLE on a resume rising edge while halt=0. The resume edge is ignored while halt=1.
- cpu_en is always 0 in HALT, and in the cycle after halt is sampled high.
- Fast mode (RUN, mode=11): cpu_en=1 every cycle.
- Slow mode (RUN, mode=10):
  - div_cnt counts 0..DIV_SLOW-1.
  - cpu_en=1 for one cycle when div_cnt wraps, so the first pulse comes DIV_SLOW cycles after entering RUN.
- div_cnt returns to 0 on any mode change, on entry to RUN, and in IDLE/HALT.
- Step edge detection ignores edges when mode≠01. A held button yields exactly one pulse.
- tick_count increments in the same cycle cpu_en is asserted; wraps all-ones→0 silently.
- running = (state==RUN); halted = (state==HALT); both registered.
- Simultaneous halt=1 and step edge: halt wins, no pulse.
- Simultaneous mode change and div_cnt wrap: no pulse; counter restarts.
- reset=0 mid-pulse: cpu_en=0 next cycle.

Optional Feature:
- Macro: CPU_CLOCK_BREAKPOINT_EN.
- When defined, adds ports:
  - pc in PC_W
  - bp_addr in PC_W
  - bp_valid in 1
  - bp_hit out 1
- When defined, behaves as follows:
  - If bp_valid=1 and pc==bp_addr is sampled in RUN, the FSM enters HALT and bp_hit is set (sticky).
  - bp_hit clears on the resume edge that exits HALT.
  - After that resume, the same pc does not re-trigger until pc changes.
  - Breakpoints are not evaluated in step mode.
- When undefined: no extra ports and no comparator; behaviour is as above.

Decomposition:
- Shared package cpu_clk_pkg holds:
  - mode encodings: MODE_STOP, MODE_STEP, MODE_SLOW, MODE_FAST
  - FSM state typedef with the fixed encodings
- One natural sub-module: edge_rise_det (a 1-bit registered rising-edge detector), instantiated for step_btn and resume.
- The divider counter stays inline.

Test Plan:
- Reset, then DIV_SLOW=4, mode=10 → cpu_en pulses at cycles 4, 8, 12 after RUN entry; tick_count=3 after cycle 12.
- Fast mode:
  - mode=11 for 10 cycles → cpu_en high 10 consecutive cycles; tick_count=10.
  - Then halt=1 → cpu_en 0 from the next cycle, halted=1, state_dbg=10.
- Step mode:
  - mode=01, step_btn held high 20 cycles → exactly one cpu_en pulse; tick_count=1.
  - Release and press again → tick_count=2.
- In HALT with halt=1:
  - Pulse resume → stays HALT.
  - Drop halt, pulse resume → IDLE, then RUN if mode=10.
- Wrap: CNT_W=4, fast mode 17 cycles → tick_count=1.
- With CPU_CLOCK_BREAKPOINT_EN:
  - bp_addr=0x40, bp_valid=1, pc ramps by 4 in fast mode → HALT when pc=0x40, bp_hit=1.
  - Resume with pc unchanged → bp_hit=0, no immediate re-halt.
